// File: rtl/band_peak_smoother.sv
// band_peak_smoother: collects one 16-band frame over valid/ready, clamps each band to 0..MAX_VAL,
// and commits all bands at once. Define BAND_DECAY_EN to build per-band peak-hold with linear decay.
module band_peak_smoother #(
  parameter int DATA_W      = 24,
  parameter int MAX_VAL     = 32767,
  parameter int DECAY_STEP  = 512,
  parameter int HOLD_FRAMES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_last,
  output logic        [DATA_W-1:0] f0,
  output logic        [DATA_W-1:0] f1,
  output logic        [DATA_W-1:0] f2,
  output logic        [DATA_W-1:0] f3,
  output logic        [DATA_W-1:0] f4,
  output logic        [DATA_W-1:0] f5,
  output logic        [DATA_W-1:0] f6,
  output logic        [DATA_W-1:0] f7,
  output logic        [DATA_W-1:0] f8,
  output logic        [DATA_W-1:0] f9,
  output logic        [DATA_W-1:0] f10,
  output logic        [DATA_W-1:0] f11,
  output logic        [DATA_W-1:0] f12,
  output logic        [DATA_W-1:0] f13,
  output logic        [DATA_W-1:0] f14,
  output logic        [DATA_W-1:0] f15,
  output logic                     done,
  output logic                     frame_err
);

  if (HOLD_FRAMES < 0 || HOLD_FRAMES > 15) begin : g_hold_chk
    $error("HOLD_FRAMES must fit the 4-bit hold counter (0..15)");
  end
  if (DECAY_STEP < 0 || DECAY_STEP > MAX_VAL) begin : g_step_chk
    $error("DECAY_STEP must lie in 0..MAX_VAL");
  end
  if (MAX_VAL <= 0 || MAX_VAL >= (2 ** (DATA_W - 1))) begin : g_max_chk
    $error("MAX_VAL must be positive and representable as a signed DATA_W value");
  end

  localparam logic [DATA_W-1:0] MAX_V = DATA_W'(MAX_VAL);

  // COLLECT: in_ready=1, beats land in the pending bank | COMMIT: bubble cycle, pending bank -> f
  typedef enum logic {
    COLLECT = 1'b0,
    COMMIT  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        band_idx_q, band_idx_d;
  logic              done_q, done_d;
  logic              frame_err_q, frame_err_d;
  logic              accept;
  logic              commit;
  logic              idx_last;
  logic [DATA_W-1:0] c;
  logic [DATA_W-1:0] pend_d;
  logic [DATA_W-1:0] f_q    [16];
  logic [DATA_W-1:0] pend_q [16];

  always_comb begin
    state_d     = state_q;
    band_idx_d  = band_idx_q;
    done_d      = 1'b0;
    frame_err_d = 1'b0;
    accept      = 1'b0;
    commit      = 1'b0;
    in_ready    = (state_q == COLLECT);
    idx_last    = (band_idx_q == 4'd15);
    case (state_q)
      COLLECT: begin
        if (in_valid) begin
          accept = 1'b1;
          if (in_last && idx_last) begin
            state_d    = COMMIT;
            band_idx_d = '0;
          end else if (in_last || idx_last) begin
            band_idx_d  = '0;
            frame_err_d = 1'b1;
          end else begin
            band_idx_d = band_idx_q + 4'd1;
          end
        end
      end
      COMMIT: begin
        commit  = 1'b1;
        done_d  = 1'b1;
        state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    if (in_data[DATA_W-1]) begin
      c = '0;
    end else if (in_data > $signed(MAX_V)) begin
      c = MAX_V;
    end else begin
      c = $unsigned(in_data);
    end
  end

`ifdef BAND_DECAY_EN
  localparam logic [DATA_W-1:0] DSTEP     = DATA_W'(DECAY_STEP);
  localparam logic [3:0]        HOLD_INIT = 4'(HOLD_FRAMES);

  logic [3:0]        h_q     [16];
  logic [3:0]        hpend_q [16];
  logic [3:0]        h_cur;
  logic [3:0]        hpend_d;
  logic [DATA_W-1:0] cur;
  logic [DATA_W-1:0] decayed;

  // Values never exceed MAX_VAL, so the guarded subtract cannot wrap.
  always_comb begin
    cur     = f_q[band_idx_q];
    h_cur   = h_q[band_idx_q];
    decayed = (cur > DSTEP) ? (cur - DSTEP) : '0;
    if (c >= cur) begin
      pend_d  = c;
      hpend_d = HOLD_INIT;
    end else if (h_cur != 4'd0) begin
      pend_d  = cur;
      hpend_d = h_cur - 4'd1;
    end else begin
      pend_d  = (c > decayed) ? c : decayed;
      hpend_d = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        h_q[i]     <= '0;
        hpend_q[i] <= '0;
      end
    end else begin
      if (accept) hpend_q[band_idx_q] <= hpend_d;
      if (commit) h_q <= hpend_q;
    end
  end
`else
  always_comb pend_d = c;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      band_idx_q  <= '0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      band_idx_q  <= band_idx_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
    end
  end

  // A complete frame rewrites all 16 pending entries, so an aborted frame needs no explicit flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        f_q[i]    <= '0;
        pend_q[i] <= '0;
      end
    end else begin
      if (accept) pend_q[band_idx_q] <= pend_d;
      if (commit) f_q <= pend_q;
    end
  end

  assign done      = done_q;
  assign frame_err = frame_err_q;
  assign f0  = f_q[0];
  assign f1  = f_q[1];
  assign f2  = f_q[2];
  assign f3  = f_q[3];
  assign f4  = f_q[4];
  assign f5  = f_q[5];
  assign f6  = f_q[6];
  assign f7  = f_q[7];
  assign f8  = f_q[8];
  assign f9  = f_q[9];
  assign f10 = f_q[10];
  assign f11 = f_q[11];
  assign f12 = f_q[12];
  assign f13 = f_q[13];
  assign f14 = f_q[14];
  assign f15 = f_q[15];

endmodule

// File: tb/tb_band_peak_smoother.sv
// Directed bench for band_peak_smoother; expectations track BAND_DECAY_EN when it is defined.
module tb_band_peak_smoother;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [23:0] in_data = '0;
  logic               in_last = 1'b0;
  logic [23:0]        f [16];
  logic               done;
  logic               frame_err;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int din [16];
    int exp [16];
  } vec_t;

  vec_t tbl [3];

  band_peak_smoother dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .f0(f[0]), .f1(f[1]), .f2(f[2]), .f3(f[3]), .f4(f[4]), .f5(f[5]),
    .f6(f[6]), .f7(f[7]), .f8(f[8]), .f9(f[9]), .f10(f[10]), .f11(f[11]),
    .f12(f[12]), .f13(f[13]), .f14(f[14]), .f15(f[15]),
    .done(done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input int d, input logic l);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = 24'(d);
    in_last  = l;
    while (!in_ready && guard < 8) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int d[16], input int e[16], input string tag, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      send_beat(d[i], i == 15);
    end
    chk({tag, " ready_low_in_bubble"}, 32'(in_ready), 32'd0);
    chk({tag, " done_not_early"}, 32'(done), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, " done_pulse"}, 32'(done), 32'd1);
    chk({tag, " ready_back"}, 32'(in_ready), 32'd1);
    chk({tag, " no_frame_err"}, 32'(frame_err), 32'd0);
    for (int i = 0; i < 16; i++) chk($sformatf("%s f%0d", tag, i), 32'(f[i]), 32'(e[i]));
    @(posedge clk);
    #1;
    chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int d [16];
    int e [16];
    int e3 [7];
    int e5 [7];

    // Frame 0 from reset, clamp frame, then an all-zero frame.
    for (int i = 0; i < 16; i++) begin
      tbl[0].din[i] = 1000 * (i + 1);
      tbl[0].exp[i] = 1000 * (i + 1);
      tbl[1].din[i] = 1000 * (i + 1) + 1;
      tbl[1].exp[i] = 1000 * (i + 1) + 1;
      tbl[2].din[i] = 0;
`ifdef BAND_DECAY_EN
      tbl[2].exp[i] = 1000 * (i + 1) + 1;
`else
      tbl[2].exp[i] = 0;
`endif
    end
    tbl[1].din[0] = -5;
    tbl[1].din[1] = 40000;
    tbl[1].din[2] = 32767;
    tbl[1].exp[1] = 32767;
    tbl[1].exp[2] = 32767;
    tbl[2].exp[1] = 0;
    tbl[2].exp[2] = 0;
`ifdef BAND_DECAY_EN
    tbl[1].exp[0] = 1000;
    tbl[2].exp[0] = 1000;
    tbl[2].exp[1] = 32767;
    tbl[2].exp[2] = 32767;
    e3 = '{10000, 10000, 10000, 10000, 10000, 9488, 8976};
    e5 = '{600, 600, 600, 600, 600, 88, 0};
`else
    tbl[1].exp[0] = 0;
    tbl[2].exp[0] = 0;
    e3 = '{10000, 0, 0, 0, 0, 0, 0};
    e5 = '{600, 0, 0, 0, 0, 0, 0};
`endif

    apply_reset();
    for (int i = 0; i < 16; i++) chk($sformatf("reset f%0d", i), 32'(f[i]), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset frame_err", 32'(frame_err), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);

    for (int k = 0; k < 3; k++) send_frame(tbl[k].din, tbl[k].exp, $sformatf("tbl%0d", k), 1'b0);

    // Asynchronous reset in the middle of beat 7.
    for (int i = 0; i < 7; i++) send_beat(7777, 1'b0);
    in_valid = 1'b1;
    in_data  = 24'(7777);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst f0", 32'(f[0]), 32'd0);
    chk("async_rst f15", 32'(f[15]), 32'd0);
    chk("async_rst done", 32'(done), 32'd0);
    chk("async_rst in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      d[i] = 100 * (i + 1);
      e[i] = 100 * (i + 1);
    end
    send_frame(d, e, "post_rst", 1'b0);

    // Early in_last on beat 9: consumed, flagged, nothing committed.
    for (int i = 0; i < 10; i++) send_beat(5000, i == 9);
    chk("err_early frame_err", 32'(frame_err), 32'd1);
    chk("err_early done", 32'(done), 32'd0);
    chk("err_early in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("err_early frame_err_one_cycle", 32'(frame_err), 32'd0);
    chk("err_early done_low", 32'(done), 32'd0);
    chk("err_early f0_kept", 32'(f[0]), 32'd100);
    chk("err_early f9_kept", 32'(f[9]), 32'd1000);

    // Sixteenth beat without in_last.
    for (int i = 0; i < 16; i++) send_beat(6000, 1'b0);
    chk("err_nolast frame_err", 32'(frame_err), 32'd1);
    chk("err_nolast done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    chk("err_nolast frame_err_one_cycle", 32'(frame_err), 32'd0);
    chk("err_nolast f15_kept", 32'(f[15]), 32'd1600);

    for (int i = 0; i < 16; i++) begin
      d[i] = 200 * (i + 1);
      e[i] = 200 * (i + 1);
    end
    send_frame(d, e, "after_err", 1'b0);

    for (int i = 0; i < 16; i++) begin
      d[i] = 300 * (i + 1);
      e[i] = 300 * (i + 1);
    end
    send_frame(d, e, "gapped", 1'b1);

    // Peak hold and decay on band 3, decay floor on band 5.
    apply_reset();
    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i < 16; i++) begin
        d[i] = 0;
        e[i] = 0;
      end
      if (k == 0) begin
        d[3] = 10000;
        d[5] = 600;
      end
      e[3] = e3[k];
      e[5] = e5[k];
      send_frame(d, e, $sformatf("decay%0d", k), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
